// File: rtl/sram_reorder_buffer_if.sv
// Producer/consumer stream bundle for the frame reorder buffer.
// master = stream endpoints, slave = buffer.
interface sram_reorder_buffer_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mode_rev;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              frame_done;

  modport master (
    output in_data, in_valid, mode_rev, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_done
  );

  modport slave (
    input  in_data, in_valid, mode_rev, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_done
  );
endinterface

// File: rtl/sram_reorder_buffer.sv
// Banked SRAM frame buffer: fill one frame, drain it fwd or reversed.
// Ports: CLK, RST (async, high), bus (slave: in_*/mode_rev/out_*/frame_done).
module sram_reorder_buffer #(
  parameter int DATA_W = 512,
  parameter int BANK_W = 128,
  parameter int DEPTH  = 64
) (
  input logic CLK,
  input logic RST,
  sram_reorder_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / BANK_W;
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_C = (AW + 1)'(DEPTH);

  typedef enum logic {RECV, DRAIN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0]     r_wptr;
  logic [AW:0]       r_rcnt;
  logic              r_mode_q;
  logic              r_rd_pend;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic [1:0]        r_fifo_cnt;
  logic              r_fifo_wr;
  logic              r_fifo_rd;
  logic              r_frame_done;

  logic              w_in_ready;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_done;
  logic              w_pop;
  logic              w_push;
  logic              w_fpop;
  logic              w_room;
  logic              w_out_valid;
  logic              w_head_last;
  logic [1:0]        w_occ;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_head_data;

  // Read data waiting in the port-B register is shown directly when
  // the FIFO is empty, so the first word appears one cycle after issue.
  assign w_out_valid = (r_fifo_cnt != 2'd0) | r_rd_pend;
  assign w_head_data = (r_fifo_cnt != 2'd0) ? r_fifo_data[r_fifo_rd]
                                            : w_rd_data;
  assign w_head_last = (r_fifo_cnt != 2'd0) ? r_fifo_last[r_fifo_rd]
                                            : r_rd_last;
  assign w_pop   = w_out_valid & bus.out_ready;
  assign w_occ   = r_fifo_cnt + {1'b0, r_rd_pend};
  assign w_room  = (w_occ - {1'b0, w_pop}) < 2'd2;
  assign w_push  = r_rd_pend & ~((r_fifo_cnt == 2'd0) & w_pop);
  assign w_fpop  = w_pop & (r_fifo_cnt != 2'd0);
  assign w_raddr = r_mode_q ? LAST_A - r_rcnt[AW-1:0]
                            : r_rcnt[AW-1:0];

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? w_head_data : '0;
  assign bus.out_last   = w_out_valid & w_head_last;
  assign bus.frame_done = r_frame_done;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      RECV: begin
        w_in_ready = 1'b1;
        w_wr_en    = bus.in_valid;
        if (bus.in_valid && r_wptr == LAST_A)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_rd_en = (r_rcnt < FULL_C) & w_room;
        if (w_pop && w_head_last) begin
          w_state_nxt = RECV;
          w_done      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= RECV;
      r_wptr       <= '0;
      r_rcnt       <= '0;
      r_mode_q     <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_last    <= 1'b0;
      r_fifo_last  <= '0;
      r_fifo_cnt   <= '0;
      r_fifo_wr    <= 1'b0;
      r_fifo_rd    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done;
      r_rd_pend    <= w_rd_en;
      if (w_wr_en) begin
        r_wptr <= r_wptr + AW'(1);
        if (r_wptr == '0)
          r_mode_q <= bus.mode_rev;
      end
      if (w_rd_en) begin
        r_rcnt    <= r_rcnt + (AW + 1)'(1);
        r_rd_last <= (r_rcnt[AW-1:0] == LAST_A);
      end else if (w_done) begin
        r_rcnt <= '0;
      end
      if (w_push) begin
        r_fifo_last[r_fifo_wr] <= r_rd_last;
        r_fifo_wr              <= ~r_fifo_wr;
      end
      if (w_fpop)
        r_fifo_rd <= ~r_fifo_rd;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_fpop};
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push)
      r_fifo_data[r_fifo_wr] <= w_rd_data;
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [BANK_W-1:0] r_mem [DEPTH];
    logic [BANK_W-1:0] r_q;

    always_ff @(posedge CLK) begin
      if (w_wr_en)
        r_mem[r_wptr] <= bus.in_data[b*BANK_W +: BANK_W];
      if (w_rd_en)
        r_q <= r_mem[w_raddr];
    end

    assign w_rd_data[b*BANK_W +: BANK_W] = r_q;
  end
endmodule

// File: tb/tb_sram_reorder_buffer.sv
// Randomised bench for sram_reorder_buffer with a frame-level model.
// Drives producer/consumer streams and checks every output cycle.
module tb_sram_reorder_buffer;
  localparam int DATA_W = 512;
  localparam int DEPTH  = 64;

  logic clk;
  logic rst;
  int   rdy_pct;

  sram_reorder_buffer_if #(.DATA_W(DATA_W)) bus ();

  sram_reorder_buffer #(
    .DATA_W(DATA_W),
    .BANK_W(128),
    .DEPTH (DEPTH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Frame-level model: collect a frame, then expect it in order.
  logic [DATA_W-1:0] wbuf [$];
  logic [DATA_W:0]   expq [$];
  bit                fmode;
  bit                draining;
  bit                exp_done;
  bit                prev_stall;
  bit                prev_valid;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  int                cyc = 0;
  int                npop = 0;
  int                ndone = 0;
  int                pops_in_frame = 0;
  int                last_frame_pops = 0;
  int                t_last_in = 0;
  int                t_first_valid = 0;
  int                t_last_pop = 0;
  int                t_done = 0;
  int                t_frame_start = 0;
  logic [DATA_W-1:0] first_word;
  logic [DATA_W-1:0] last_word;

  always @(negedge clk) begin
    logic [DATA_W:0] f;
    bit acc;
    bit pop;
    cyc++;
    if (rst) begin
      wbuf.delete();
      expq.delete();
      draining   = 0;
      exp_done   = 0;
      prev_stall = 0;
      prev_valid = 0;
      pops_in_frame = 0;
      chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
      chk("rst_out_last", 512'(bus.out_last), 512'(0));
      chk("rst_frame_done", 512'(bus.frame_done), 512'(0));
      chk("rst_out_data", bus.out_data, 512'(0));
      chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
    end else begin
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      chk("in_ready", 512'(bus.in_ready), 512'(!draining));
      chk("frame_done", 512'(bus.frame_done), 512'(exp_done));
      if (bus.frame_done) begin
        t_done = cyc;
        ndone++;
      end
      if (!draining)
        chk("idle_valid", 512'(bus.out_valid), 512'(0));
      if (prev_stall) begin
        chk("stall_valid", 512'(bus.out_valid), 512'(1));
        chk("stall_data", bus.out_data, prev_data);
        chk("stall_last", 512'(bus.out_last), 512'(prev_last));
      end
      if (bus.out_valid && !prev_valid)
        t_first_valid = cyc;
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_valid", 512'(bus.out_valid), 512'(0));
        end else begin
          f = expq[0];
          chk("out_data", bus.out_data, f[DATA_W-1:0]);
          chk("out_last", 512'(bus.out_last), 512'(f[DATA_W]));
        end
      end
      exp_done = 0;
      if (pop && expq.size() != 0) begin
        f = expq.pop_front();
        npop++;
        if (pops_in_frame == 0)
          first_word = bus.out_data;
        pops_in_frame++;
        if (f[DATA_W]) begin
          exp_done        = 1;
          draining        = 0;
          last_word       = bus.out_data;
          t_last_pop      = cyc;
          last_frame_pops = pops_in_frame;
          pops_in_frame   = 0;
        end
      end
      if (acc) begin
        if (wbuf.size() == 0) begin
          fmode = bus.mode_rev;
          t_frame_start = cyc;
        end
        wbuf.push_back(bus.in_data);
        if (wbuf.size() == DEPTH) begin
          for (int k = 0; k < DEPTH; k++) begin
            int a;
            a = fmode ? DEPTH - 1 - k : k;
            expq.push_back({k == DEPTH - 1, wbuf[a]});
          end
          wbuf.delete();
          draining  = 1;
          t_last_in = cyc;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_valid = bus.out_valid;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W / 32; k++)
      r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic send_frame(input int kind, input bit mode,
                            input bit toggle, input int gap_pct);
    logic [127:0]      v;
    logic [DATA_W-1:0] w;
    bit                got;
    int                bud;
    for (int i = 0; i < DEPTH; i++) begin
      v = 128'(i);
      w = (kind == 0) ? {4{v}} : rnd_word();
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = rnd_word();
        bus.mode_rev = 1'($urandom);
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      if (i == 0)
        bus.mode_rev = mode;
      else if (toggle && i == DEPTH / 2)
        bus.mode_rev = ~mode;
      bud = 0;
      do begin
        @(negedge clk);
        got = bus.in_ready;
        @(posedge clk);
        #1;
        bud++;
      end while (!got && bud < 4000);
      if (!got) begin
        chk("send_timeout", 512'(got), 512'(1));
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int bud;
    d0  = ndone;
    bud = 0;
    while (ndone == d0 && bud < 5000) begin
      @(posedge clk);
      #1;
      bud++;
    end
    if (ndone == d0)
      chk("done_timeout", 512'(ndone), 512'(d0 + 1));
  endtask

  initial begin
    int p0;
    int bud;
    logic [127:0] v0;
    logic [127:0] v63;
    v0  = 128'(0);
    v63 = 128'(63);
    rst          = 1'b1;
    rdy_pct      = 100;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode_rev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 512'(bus.in_ready), 512'(1));
    chk("reset_out_valid", 512'(bus.out_valid), 512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // forward frame, literal timing and data
    send_frame(0, 1'b0, 1'b0, 0);
    wait_done();
    chk("fwd_valid_lat", 512'(t_first_valid - t_last_in), 512'(2));
    chk("fwd_last_lat", 512'(t_last_pop - t_last_in), 512'(DEPTH + 1));
    chk("fwd_done_lat", 512'(t_done - t_last_pop), 512'(1));
    chk("fwd_first", first_word, {4{v0}});
    chk("fwd_last", last_word, {4{v63}});
    chk("fwd_count", 512'(last_frame_pops), 512'(DEPTH));

    // reverse frame with mid-frame mode toggle
    send_frame(0, 1'b1, 1'b1, 0);
    wait_done();
    chk("rev_first", first_word, {4{v63}});
    chk("rev_last", last_word, {4{v0}});
    chk("rev_count", 512'(last_frame_pops), 512'(DEPTH));

    // random backpressure and input gaps
    rdy_pct = 50;
    send_frame(1, 1'b0, 1'b0, 50);
    wait_done();
    chk("bp_count", 512'(last_frame_pops), 512'(DEPTH));
    rdy_pct = 100;

    // input held during drain; next word 0 lands on frame_done cycle
    send_frame(1, 1'b0, 1'b0, 0);
    send_frame(1, 1'b1, 1'b0, 0);
    chk("drain_hold_accept", 512'(t_frame_start), 512'(t_done));
    wait_done();
    chk("b2b_count", 512'(last_frame_pops), 512'(DEPTH));

    // reset in the middle of a drain
    send_frame(1, 1'b0, 1'b0, 0);
    p0  = npop;
    bud = 0;
    while (npop < p0 + 10 && bud < 2000) begin
      @(posedge clk);
      #1;
      bud++;
    end
    chk("mid_pops", 512'(npop - p0), 512'(10));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 512'(bus.out_valid), 512'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", 512'(bus.in_ready), 512'(1));
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, 1'b0, 0);
    wait_done();
    chk("post_rst_first", first_word, {4{v0}});
    chk("post_rst_last", last_word, {4{v63}});
    chk("post_rst_count", 512'(last_frame_pops), 512'(DEPTH));

    // a few fully random frames
    rdy_pct = 60;
    for (int n = 0; n < 3; n++) begin
      send_frame(1, 1'($urandom), 1'b1, 30);
      wait_done();
      chk("rnd_count", 512'(last_frame_pops), 512'(DEPTH));
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_reorder_buffer.md
# sram_reorder_buffer

Parametrised frame buffer that writes one full frame of `DEPTH` words into banked synchronous dual-port SRAM. It then streams the frame back out in forward or reverse order under valid/ready flow control on both sides. It sits between a producer stream and a consumer that needs frame-granular reordering. It adds backpressure, selectable read order and a per-frame last/done indication.

## Interface

**Parameters**
- `DATA_W`, default 512: word width; must be a multiple of `BANK_W`.
- `BANK_W`, default 128: width of one SRAM bank; the buffer uses `DATA_W/BANK_W` banks sharing one address.
- `DEPTH`, default 64: words per frame; power of two, ≥ 2.
- `AW`: localparam, `$clog2(DEPTH)`; the address and pointer width.

**Ports**
- `CLK` in 1: clock.
- `RST` in 1: asynchronous reset, active-high.
- `in_data` in `DATA_W`: input word.
- `in_valid` in 1: input word present.
- `in_ready` out 1: block accepts a word; transfer occurs when `in_valid && in_ready`.
- `mode_rev` in 1: read order; 0 = forward (address 0..DEPTH-1), 1 = reverse (address DEPTH-1..0).
- `out_data` out `DATA_W`: output word, taken from the head of the output FIFO.
- `out_valid` out 1: output word present.
- `out_ready` in 1: consumer accepts; transfer occurs when `out_valid && out_ready`.
- `out_last` out 1: high with the final word of a frame; qualified by `out_valid`.
- `frame_done` out 1: one-cycle pulse after the final word of a frame transfers.

## Operation

**Memory**
- Behavioural synchronous dual-port array, one per bank.
- Port A writes.
- Port B reads; read data is valid the cycle after the read is issued.

**State machine**: `RECV` → `DRAIN` → `RECV`.
- **RECV**
  - `in_ready` = 1.
  - Each accepted word is written to address `wptr`, and `wptr` increments.
  - `mode_rev` is sampled into `mode_q` on the first accepted word of the frame (`wptr`==0). Changes to `mode_rev` later in the frame are ignored.
  - When the accepted word has `wptr`==DEPTH-1: `wptr` returns to 0 and the next state is `DRAIN`.
  - Input gaps (`in_valid`=0) are allowed; the frame completes on word count only.
- **DRAIN**
  - `in_ready` = 0; an asserted `in_valid` is ignored and no data is accepted.
  - `rcnt` counts reads issued, 0..DEPTH.
  - Read address is `rcnt` when `mode_q`=0, and `DEPTH-1-rcnt` when `mode_q`=1.
  - Output FIFO: 2 entries, holding data plus a last flag.
  - A read is issued in a cycle when `rcnt` < DEPTH and `fifo_cnt + rd_pend - pop` < 2, where `pop = out_valid && out_ready`.
  - Returned read data is pushed into the FIFO the next cycle.
  - The last flag is set on the word read with `rcnt`==DEPTH-1.
  - When the popped word has its last flag set: next state is `RECV`, `rcnt` is cleared, and `frame_done` pulses for one cycle.
- Read and write never overlap, so there are no address collisions.
- Arithmetic: all pointers are `AW` bits, with `rcnt` at `AW+1` bits. There is no wrap beyond DEPTH within a frame.

## Timing

**Reset values**
- `in_ready` = 1 (state `RECV`).
- `out_valid`, `out_last`, `frame_done` = 0.
- `out_data` = 0.
- `wptr`, `rcnt`, FIFO count, `rd_pend` = 0.
- Memory contents are not reset.

**Latency**: take T as the cycle in which the last input word is accepted.
- `DRAIN` is entered at T+1, and the first read is issued at T+1.
- `out_valid` = 1 from T+2.
- With `out_ready` held at 1:
  - Words transfer at T+2 through T+1+DEPTH, one per cycle.
  - `out_last` is high at T+1+DEPTH.
  - `frame_done` and `in_ready` are both 1 at T+2+DEPTH.

**Backpressure**
- While `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- No word is dropped or duplicated.
- Full throughput resumes the cycle after `out_ready` returns to 1.

**Reset mid-operation**: asserting `RST` in any state immediately does all of the following:
- Forces `RECV`.
- Flushes the FIFO and any in-flight read.
- Clears the outputs.
- The partial frame is discarded.
- `in_ready` = 1 once `RST` deasserts.

## Test plan

1. **Forward frame.** Reset, `mode_rev`=0, 64 words with word i = {4{i[127:0]}}, `out_ready`=1.
   - Outputs are 0..63.
   - `out_valid` rises 2 cycles after the last input.
   - `out_last` is on word 63; `frame_done` pulses the cycle after it.
2. **Reverse frame.** `mode_rev`=1 on word 0, then toggled mid-frame.
   - Outputs are 63..0; the mid-frame toggle is ignored.
   - `out_last` is on word 0.
3. **Random backpressure.** `out_ready` random at 50%, `in_valid` random at 50%.
   - All 64 words arrive in order.
   - `out_data` is stable during stalls.
   - Total transfers = 64.
4. **Input during drain.** `in_valid`=1 held throughout `DRAIN`.
   - `in_ready`=0 and nothing is written.
   - The next frame's word 0 is accepted at the `frame_done` cycle and reads back correctly.
5. **Back-to-back frames.** Two frames: forward with `out_ready`=1, then reverse.
   - The second frame's outputs match its own data in reverse.
   - No first-frame data leaks into the second frame.
6. **Reset mid-drain.** Assert `RST` after 10 output words, then send a new forward frame.
   - `out_valid`=0 immediately; `in_ready`=1 after release.
   - The new frame outputs 0..63 correctly.
